alu16_sequencer: RTL and testbench

Multi-cycle 16-bit arithmetic sequencer for the GB80 ALU. It runs ADD/ADC/SUB/SBC/INC/DEC on 16-bit operands by driving one internal 8-bit ripple-carry adder twice: low byte first, then high byte with the chained carry. It sits between the instruction decoder and the 16-bit register file and serves ADD HL,rr, INC rr, DEC rr and similar. It uses a start/done handshake and produces Game Boy–style Z/N/H/C flags.

---
 rtl/alu16_sequencer_if.sv | 28 ++
 rtl/alu16_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu16_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu16_sequencer_if.sv
// Start/done handshake bundle between the instruction decoder and the 16-bit ALU sequencer.
// The decoder uses the master modport and the sequencer uses the slave modport.
interface alu16_sequencer_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [WORD_WIDTH-1:0] i_data_A;
  logic [WORD_WIDTH-1:0] i_data_B;
  logic                  i_carry;
  logic                  o_busy;
  logic                  o_done;
  logic [WORD_WIDTH-1:0] o_result;
  logic                  o_zero;
  logic                  o_subtract;
  logic                  o_half_carry;
  logic                  o_carry;

  modport master (
    output i_start, i_op, i_data_A, i_data_B, i_carry,
    input  o_busy, o_done, o_result, o_zero, o_subtract, o_half_carry, o_carry
  );

  modport slave (
    input  i_start, i_op, i_data_A, i_data_B, i_carry,
    output o_busy, o_done, o_result, o_zero, o_subtract, o_half_carry, o_carry
  );
endinterface

// File: rtl/alu16_sequencer.sv
// Two-pass 16-bit ADD/ADC/SUB/SBC/INC/DEC built around a single half-width adder,
// producing Game Boy style Z/N/H/C flags.
module alu16_sequencer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  alu16_sequencer_if.slave bus
);
  localparam int HALF_W = WORD_WIDTH / 2;
  localparam int NIB_W  = HALF_W - 4;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                state, state_next;
  logic                  accept;
  logic [2:0]            op_q;
  logic [WORD_WIDTH-1:0] a_q, b_q;
  logic                  carry_in_q;
  logic [HALF_W-1:0]     lo_sum;
  logic                  mid_carry;
  logic [WORD_WIDTH-1:0] result;
  logic                  zero, subtract, half_carry, carry;
  logic                  busy, done;

  logic [WORD_WIDTH-1:0] b_sel;
  logic                  cin_sel;
  logic                  sub_op;
  logic [HALF_W-1:0]     add_x, add_y;
  logic                  add_c;
  logic [HALF_W:0]       add_sum;
  logic                  add_h;
  logic [WORD_WIDTH-1:0] full_sum;

  function automatic logic [HALF_W:0] add_half(input logic [HALF_W-1:0] x,
                                               input logic [HALF_W-1:0] y,
                                               input logic c);
    add_half = {1'b0, x} + {1'b0, y} + {{HALF_W{1'b0}}, c};
  endfunction

  // Carry out of the top bit of the low nibble field of a half-width add.
  function automatic logic nib_carry(input logic [HALF_W-1:0] x,
                                     input logic [HALF_W-1:0] y,
                                     input logic c);
    logic [NIB_W:0] s;
    s = {1'b0, x[NIB_W-1:0]} + {1'b0, y[NIB_W-1:0]} + {{NIB_W{1'b0}}, c};
    nib_carry = s[NIB_W];
  endfunction

  assign accept = bus.i_start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_start) state_next = LOW;
      LOW:     state_next = HIGH;
      HIGH:    state_next = DONE;
      DONE:    state_next = bus.i_start ? LOW : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == LOW) || (state == HIGH);
    done = (state == DONE);
  end

  // Subtraction forms are two's complement add with an inverted carry sense.
  always_comb begin
    b_sel   = b_q;
    cin_sel = 1'b0;
    sub_op  = 1'b0;
    case (op_q)
      3'b001: cin_sel = carry_in_q;
      3'b010: begin b_sel = ~b_q; cin_sel = 1'b1;        sub_op = 1'b1; end
      3'b011: begin b_sel = ~b_q; cin_sel = ~carry_in_q; sub_op = 1'b1; end
      3'b100: begin b_sel = '0;   cin_sel = 1'b1; end
      3'b101: begin b_sel = '1;   cin_sel = 1'b0;        sub_op = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    add_x = a_q[HALF_W-1:0];
    add_y = b_sel[HALF_W-1:0];
    add_c = cin_sel;
    if (state == HIGH) begin
      add_x = a_q[WORD_WIDTH-1:HALF_W];
      add_y = b_sel[WORD_WIDTH-1:HALF_W];
      add_c = mid_carry;
    end
    add_sum  = add_half(add_x, add_y, add_c);
    add_h    = nib_carry(add_x, add_y, add_c);
    full_sum = {add_sum[HALF_W-1:0], lo_sum};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_in_q <= 1'b0;
      lo_sum     <= '0;
      mid_carry  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      subtract   <= 1'b0;
      half_carry <= 1'b0;
      carry      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.i_op;
        a_q        <= bus.i_data_A;
        b_q        <= bus.i_data_B;
        carry_in_q <= bus.i_carry;
      end
      // Low pass: keep the low half and the carry chained into the high pass.
      if (state == LOW) begin
        lo_sum    <= add_sum[HALF_W-1:0];
        mid_carry <= add_sum[HALF_W];
      end
      // High pass: the architected result and flags update only here.
      if (state == HIGH) begin
        result     <= full_sum;
        zero       <= (full_sum == '0);
        subtract   <= sub_op;
        half_carry <= add_h ^ sub_op;
        carry      <= add_sum[HALF_W] ^ sub_op;
      end
    end
  end

  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_result     = result;
  assign bus.o_zero       = zero;
  assign bus.o_subtract   = subtract;
  assign bus.o_half_carry = half_carry;
  assign bus.o_carry      = carry;
endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer: expected result/flags are queued at each accepted
// start and compared whenever the sequencer pulses done.
module tb_alu16_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu16_sequencer_if #(.WORD_WIDTH(16)) bus ();
  alu16_sequencer #(.WORD_WIDTH(16)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: straight 16-bit add with the carry into bit 12 taken as H.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [15:0] bs;
    logic c, n;
    logic [16:0] full;
    logic [12:0] low12;
    bs = b; c = 1'b0; n = 1'b0;
    case (op)
      3'd1: c = cin;
      3'd2: begin bs = ~b; c = 1'b1; n = 1'b1; end
      3'd3: begin bs = ~b; c = ~cin; n = 1'b1; end
      3'd4: begin bs = 16'h0000; c = 1'b1; end
      3'd5: begin bs = 16'hFFFF; c = 1'b0; n = 1'b1; end
      default: ;
    endcase
    full  = {1'b0, a} + {1'b0, bs} + {16'd0, c};
    low12 = {1'b0, a[11:0]} + {1'b0, bs[11:0]} + {12'd0, c};
    model = {full[15:0], (full[15:0] == 16'h0000), n, low12[12] ^ n, full[16] ^ n};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    bus.i_op = op; bus.i_data_A = a; bus.i_data_B = b; bus.i_carry = cin;
  endtask

  // Called one time unit after a rising edge with the sequencer idle or done.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
    drive(op, a, b, cin);
    bus.i_start = 1'b1;
    exp_q.push_back(model(op, a, b, cin));
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
    check("busy_in_low", bus.o_busy, 1);
    check("no_done_in_low", bus.o_done, 0);
    @(posedge clk); #1;
    check("busy_in_high", {bus.o_busy, bus.o_done}, 2'b10);
    @(posedge clk); #1;
    check("done_after_edge2", {bus.o_busy, bus.o_done}, 2'b01);
    @(posedge clk); #1;
    check("done_drops", {bus.o_busy, bus.o_done}, 2'b00);
  endtask

  always @(negedge clk) begin
    if (rst) prev_done = 1'b0;
    else begin
      if (bus.o_done) begin
        done_cnt++;
        check("done_not_consecutive", prev_done, 0);
        check("expectation_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("result_flags", {bus.o_result, bus.o_zero, bus.o_subtract,
                                 bus.o_half_carry, bus.o_carry}, exp_q.pop_front());
      end
      prev_done = bus.o_done;
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.i_start = 1'b0;
    drive(3'd0, 16'h0000, 16'h0000, 1'b0);
    #12;
    check("reset_outputs", {bus.o_busy, bus.o_done, bus.o_result, bus.o_zero,
                            bus.o_subtract, bus.o_half_carry, bus.o_carry}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 16'h0FFF, 16'h0001, 1'b0);
    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(3'd1, 16'h0000, 16'h0000, 1'b1);
    run_op(3'd2, 16'h1000, 16'h0001, 1'b0);
    run_op(3'd3, 16'h0000, 16'h0000, 1'b1);
    run_op(3'd4, 16'hFFFF, 16'h1234, 1'b0);
    run_op(3'd5, 16'h0000, 16'h0000, 1'b0);
    run_op(3'd7, 16'h8000, 16'h8000, 1'b1);
    run_op(3'd6, 16'h1234, 16'h4321, 1'b1);
    drive(3'd2, 16'hAAAA, 16'h1111, 1'b1);
    @(posedge clk); #1;
    check("result_holds_in_idle", bus.o_result, 16'h5555);

    // Start held for nine edges with operands changing every cycle.
    base = done_cnt;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] op;
      logic [15:0] a, b;
      logic c;
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      drive(op, a, b, c);
      bus.i_start = 1'b1;
      if (i % 3 == 0) exp_q.push_back(model(op, a, b, c));
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("back_to_back_done_count", done_cnt - base, 3);
    check("back_to_back_queue_empty", exp_q.size(), 0);

    // Abort an operation with an asynchronous reset in the HIGH pass.
    run_op(3'd0, 16'h0FFF, 16'h0001, 1'b0);
    check("pre_abort_result", bus.o_result, 16'h1000);
    base = done_cnt;
    drive(3'd2, 16'h5000, 16'h0123, 1'b0);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #2;
    check("busy_before_abort", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {bus.o_busy, bus.o_done, bus.o_result, bus.o_zero,
                                  bus.o_subtract, bus.o_half_carry, bus.o_carry}, 0);
    bus.i_start = 1'b1;
    drive(3'd0, 16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    check("start_dropped_in_reset", {bus.o_busy, bus.o_done}, 2'b00);
    rst = 1'b0;
    exp_q.push_back(model(3'd0, 16'h00FF, 16'h0001, 1'b0));
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("first_start_after_release", bus.o_busy, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_after_release", bus.o_done, 1);
    check("aborted_op_no_done", done_cnt - base, 0);
    @(posedge clk); #1;
    check("idle_after_release_op", {bus.o_busy, bus.o_done}, 2'b00);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
